// File: rtl/fmac_pkg.sv
// Shared constants, FSM state type and bias helper for the FMAC Booth multiplier datapath.
package fmac_pkg;

    localparam int PP_WIDTH  = 10;
    localparam int NUM_PP    = 5;
    localparam int P_WIDTH   = PP_WIDTH + 2 * (NUM_PP - 1);
    localparam int CNT_WIDTH = $clog2(NUM_PP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accState_t;

    // Each encoded partial product carries +2^(PP_WIDTH-1) at its own weight;
    // the bias is the negated sum of those offsets so they cancel in the total.
    function automatic logic [P_WIDTH-1:0] booth_bias(input int ppWidth, input int numPp);
        logic [P_WIDTH-1:0] offsetSum;
        offsetSum = '0;
        for (int i = 0; i < numPp; i++) begin
            offsetSum = offsetSum + (P_WIDTH'(1) << (ppWidth - 1 + 2 * i));
        end
        return (~offsetSum) + P_WIDTH'(1);
    endfunction

    localparam logic [P_WIDTH-1:0] BIAS = booth_bias(PP_WIDTH, NUM_PP);

endpackage

// File: rtl/pp_align_add.sv
// Aligns one encoded partial product to its radix-4 weight and adds it to the running sum.
module pp_align_add
    import fmac_pkg::*;
(
    input  logic [P_WIDTH-1:0]   acc,
    input  logic [PP_WIDTH-1:0]  pp,
    input  logic [CNT_WIDTH-1:0] cnt,
    output logic [P_WIDTH-1:0]   sum
);

    logic [P_WIDTH-1:0] ppExt;

    // Zero-extend: the inverted-sign MSB encoding makes the add purely unsigned.
    assign ppExt = P_WIDTH'(pp);
    assign sum   = acc + (ppExt << {cnt, 1'b0});

endmodule

// File: rtl/booth_pp_accumulator.sv
// Collects NUM_PP sign-extension-encoded Booth partial products, removes the encoding
// bias and hands the signed product downstream over valid/ready.
module booth_pp_accumulator
    import fmac_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ppValid,
    output logic                ppReady,
    input  logic                ppFirst,
    input  logic [PP_WIDTH-1:0] partialProduct,
    output logic                productValid,
    input  logic                productReady,
    output logic [P_WIDTH-1:0]  product,
    output logic                protocolError
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_PP - 1);

    accState_t            stateReg, stateNext;
    logic [P_WIDTH-1:0]   accReg, accNext;
    logic [CNT_WIDTH-1:0] cntReg, cntNext;
    logic [P_WIDTH-1:0]   productReg, productNext;
    logic                 productValidReg, productValidNext;
    logic                 protocolErrorReg, protocolErrorNext;

    logic                 accept;
    logic [P_WIDTH-1:0]   addBase;
    logic [CNT_WIDTH-1:0] addCnt;
    logic [P_WIDTH-1:0]   addSum;

    assign ppReady = (stateReg == DONE) ? productReady : 1'b1;
    assign accept  = ppValid && ppReady;

    // A first beat always restarts from the bias at weight 0, so one adder serves both cases.
    assign addBase = ppFirst ? BIAS : accReg;
    assign addCnt  = ppFirst ? '0 : cntReg;

    pp_align_add alignAdd (
        .acc (addBase),
        .pp  (partialProduct),
        .cnt (addCnt),
        .sum (addSum)
    );

    always_comb begin
        stateNext         = stateReg;
        accNext           = accReg;
        cntNext           = cntReg;
        productNext       = productReg;
        productValidNext  = productValidReg;
        protocolErrorNext = 1'b0;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    if (ppFirst) begin
                        accNext   = addSum;
                        cntNext   = CNT_WIDTH'(1);
                        stateNext = ACCUM;
                    end else begin
                        protocolErrorNext = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    accNext = addSum;
                    if (ppFirst) begin
                        protocolErrorNext = 1'b1;
                        cntNext           = CNT_WIDTH'(1);
                    end else if (cntReg == LAST_CNT) begin
                        stateNext        = DONE;
                        productNext      = addSum;
                        productValidNext = 1'b1;
                        cntNext          = '0;
                    end else begin
                        cntNext = cntReg + CNT_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (productReady) begin
                    productValidNext = 1'b0;
                    stateNext        = IDLE;
                    if (accept) begin
                        if (ppFirst) begin
                            accNext   = addSum;
                            cntNext   = CNT_WIDTH'(1);
                            stateNext = ACCUM;
                        end else begin
                            protocolErrorNext = 1'b1;
                        end
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg         <= IDLE;
            accReg           <= '0;
            cntReg           <= '0;
            productReg       <= '0;
            productValidReg  <= 1'b0;
            protocolErrorReg <= 1'b0;
        end else begin
            stateReg         <= stateNext;
            accReg           <= accNext;
            cntReg           <= cntNext;
            productReg       <= productNext;
            productValidReg  <= productValidNext;
            protocolErrorReg <= protocolErrorNext;
        end
    end

    assign product       = productReg;
    assign productValid  = productValidReg;
    assign protocolError = protocolErrorReg;

endmodule
